// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - state encodings and control-enable bundles for pipeline_ctrl
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_MEM_WAIT = 3'd1,
    ST_LU_STALL = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_HALT     = 3'd4
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
  } ctl_t;

  // Canned enable patterns shared by every state of the sequencer.
  localparam ctl_t CTL_FREEZE = 5'b00000;
  localparam ctl_t CTL_BUBBLE = 5'b00011;
  localparam ctl_t CTL_RUN    = 5'b11010;
  localparam ctl_t CTL_FLUSH  = 5'b11110;
  localparam ctl_t CTL_RESET  = 5'b00001;

endpackage

// File: rtl/pipeline_ctrl_load_use_detect.sv
// rtl/pipeline_ctrl_load_use_detect.sv - load-use hazard between the load in EX and the instruction in ID
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [4:0] ex_rt,
  input  logic       ex_mem_read,
  output logic       lu
);

  // A load into the zero register never produces a value worth waiting for.
  assign lu = ex_mem_read && (ex_rt != REG_ZERO) &&
              ((ex_rt == id_rs) || (ex_rt == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
// Fixed priority: memory wait, halt, load-use, branch/jump flush.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int FLUSH_CYCLES      = 1,
  parameter int CNT_W             = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_busy,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_bubble,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [3:0] LU_INIT = 4'(LOAD_STALL_CYCLES - 1);
  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     st;
  logic [3:0] cnt;
  logic       lu;
  ctl_t       ctl;

  load_use_detect u_lu (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .ex_rt       (ex_rt),
    .ex_mem_read (ex_mem_read),
    .lu          (lu)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      st  <= ST_RUN;
      cnt <= 4'd0;
    end else begin
      case (st)
        ST_RUN: begin
          if (mem_busy) begin
            st <= ST_MEM_WAIT;
          end else if (halt_req) begin
            st <= ST_HALT;
          end else if (lu) begin
            cnt <= LU_INIT;
            st  <= (LU_INIT != 4'd0) ? ST_LU_STALL : ST_RUN;
          end else if (branch_taken || jump) begin
            cnt <= FL_INIT;
            st  <= (FL_INIT != 4'd0) ? ST_FLUSH : ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_busy) st <= ST_RUN;
        end
        // Both countdown states pause on a memory wait and resume where they left off.
        ST_LU_STALL, ST_FLUSH: begin
          if (!mem_busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) st <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (resume) st <= ST_RUN;
        end
        default: st <= ST_RUN;
      endcase
    end
  end

  // A lu in the same cycle as a branch wins, so the stale-operand branch is dropped.
  always_comb begin
    ctl = CTL_FREEZE;
    if (RST) begin
      ctl = CTL_RESET;
    end else begin
      case (st)
        ST_RUN: begin
          if (mem_busy)                    ctl = CTL_FREEZE;
          else if (halt_req || lu)         ctl = CTL_BUBBLE;
          else if (branch_taken || jump)   ctl = CTL_FLUSH;
          else                             ctl = CTL_RUN;
        end
        ST_MEM_WAIT: ctl = CTL_FREEZE;
        ST_LU_STALL: ctl = mem_busy ? CTL_FREEZE : CTL_BUBBLE;
        ST_FLUSH:    ctl = mem_busy ? CTL_FREEZE : CTL_FLUSH;
        ST_HALT:     ctl = CTL_BUBBLE;
        default:     ctl = CTL_FREEZE;
      endcase
    end
  end

  assign pc_write    = ctl.pc_write;
  assign ifid_write  = ctl.ifid_write;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_write  = ctl.idex_write;
  assign idex_bubble = ctl.idex_bubble;
  assign state       = st;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - bench for pipeline_ctrl with two parameterisations
module tb_pipeline_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_mem_read, branch_taken, jump, mem_busy, halt_req, resume;

  logic        pcw_a, ifw_a, fl_a, idw_a, bub_a;
  logic        pcw_b, ifw_b, fl_b, idw_b, bub_b;
  logic [2:0]  st_a, st_b;
  logic [15:0] sc_a;
  logic [3:0]  sc_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  pipeline_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .jump(jump),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .pc_write(pcw_a), .ifid_write(ifw_a), .ifid_flush(fl_a), .idex_write(idw_a),
    .idex_bubble(bub_a), .state(st_a), .stall_cnt(sc_a)
  );

  pipeline_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .branch_taken(branch_taken), .jump(jump),
    .mem_busy(mem_busy), .halt_req(halt_req), .resume(resume),
    .pc_write(pcw_b), .ifid_write(ifw_b), .ifid_flush(fl_b), .idex_write(idw_b),
    .idex_bubble(bub_b), .state(st_b), .stall_cnt(sc_b)
  );

  // Expected enable patterns as {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}.
  localparam logic [4:0] O_RUN = 5'b11010;
  localparam logic [4:0] O_FLS = 5'b11110;
  localparam logic [4:0] O_BUB = 5'b00011;
  localparam logic [4:0] O_FRZ = 5'b00000;
  localparam logic [4:0] O_RST = 5'b00001;
  localparam int M_RUN = 0, M_MEM = 1, M_HALT = 2;

  int LCY  [2] = '{1, 3};
  int FCY  [2] = '{1, 2};
  int SMAX [2] = '{65535, 15};

  // Model: mode plus remaining bubble/flush cycles still owed, and stall count.
  int mode [2] = '{0, 0};
  int rb   [2] = '{0, 0};
  int rf   [2] = '{0, 0};
  int sc   [2] = '{0, 0};
  int nmode[2], nrb[2], nrf[2], nsc[2];
  logic [2:0] exp_st[2];
  logic [4:0] exp_o [2];

  function automatic logic [35:0] got();
    return {st_a, pcw_a, ifw_a, fl_a, idw_a, bub_a,
            st_b, pcw_b, ifw_b, fl_b, idw_b, bub_b, sc_a, sc_b};
  endfunction

  function automatic logic [35:0] want();
    return {exp_st[0], exp_o[0], exp_st[1], exp_o[1], 16'(sc[0]), 4'(sc[1])};
  endfunction

  task automatic idle();
    RST = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    mem_busy = 1'b0; halt_req = 1'b0; resume = 1'b0;
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
  endtask

  task automatic settle();
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      int m = mode[i];
      int b = rb[i];
      int f = rf[i];
      int s = sc[i];
      logic lu;
      logic [4:0] o;
      lu = ex_mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
      exp_st[i] = (m == M_MEM) ? 3'd1 : (m == M_HALT) ? 3'd4 :
                  (b > 0) ? 3'd2 : (f > 0) ? 3'd3 : 3'd0;
      if (RST) begin
        o = O_RST; m = M_RUN; b = 0; f = 0; s = 0;
      end else begin
        if (m == M_MEM) begin
          o = O_FRZ;
          if (!mem_busy) m = M_RUN;
        end else if (m == M_HALT) begin
          o = O_BUB;
          if (resume) m = M_RUN;
        end else if (b > 0) begin
          if (mem_busy) o = O_FRZ; else begin o = O_BUB; b--; end
        end else if (f > 0) begin
          if (mem_busy) o = O_FRZ; else begin o = O_FLS; f--; end
        end else if (mem_busy) begin
          o = O_FRZ; m = M_MEM;
        end else if (halt_req) begin
          o = O_BUB; m = M_HALT;
        end else if (lu) begin
          o = O_BUB; b = LCY[i] - 1;
        end else if (branch_taken || jump) begin
          o = O_FLS; f = FCY[i] - 1;
        end else begin
          o = O_RUN;
        end
        if (!o[4] && s < SMAX[i]) s++;
      end
      exp_o[i] = o; nmode[i] = m; nrb[i] = b; nrf[i] = f; nsc[i] = s;
    end
  endtask

  task automatic clock();
    for (int i = 0; i < 2; i++) begin
      mode[i] = nmode[i]; rb[i] = nrb[i]; rf[i] = nrf[i]; sc[i] = nsc[i];
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      idle(); RST = 1'b1; mem_busy = (c == 1); halt_req = (c == 2);
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL reset c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  task automatic test_load_use();
    for (int c = 0; c < 10; c++) begin
      idle();
      if (c == 0 || c == 5) begin ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; end
      if (c == 5) ex_rt = 5'd0;
      if (c == 5) id_rs = 5'd0;
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL load_use c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  task automatic test_lu_branch();
    for (int c = 0; c < 8; c++) begin
      idle();
      if (c == 0) begin ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; end
      branch_taken = (c < 4);
      jump = (c == 6);
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL lu_branch c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  task automatic test_mem_in_stall();
    for (int c = 0; c < 12; c++) begin
      idle();
      if (c == 0) begin ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4; end
      mem_busy = (c >= 2 && c <= 5) || (c == 8);
      jump = (c == 7);
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL mem_in_stall c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  task automatic test_halt_reset();
    for (int c = 0; c < 16; c++) begin
      idle();
      halt_req = (c <= 4) || (c == 8);
      RST = (c == 5);
      resume = (c == 11);
      jump = (c == 12);
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL halt_reset c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 24; c++) begin
      idle();
      mem_busy = (c < 20);
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL saturate c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      RST          = ($urandom_range(0, 199) == 0);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      mem_busy     = ($urandom_range(0, 7) == 0);
      halt_req     = ($urandom_range(0, 15) == 0);
      resume       = ($urandom_range(0, 3) == 0);
      id_rs        = 5'($urandom_range(0, 3));
      id_rt        = 5'($urandom_range(0, 3));
      ex_rt        = 5'($urandom_range(0, 3));
      settle();
      vectors++;
      if (got() !== want()) begin
        miscompares++;
        $display("FAIL random c%0d: got %h expected %h", c, got(), want());
      end
      clock();
    end
  endtask

  initial begin
    idle();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    test_reset();
    test_load_use();
    test_lu_branch();
    test_mem_in_stall();
    test_halt_reset();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
